// File: rtl/ui_panel_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package : ui_pkg                                                   |
// | Default constants, repeat-state encoding and width helper for the  |
// | UI panel controller.                                               |
// | Rev     : 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
package ui_pkg;

  localparam int DEF_NUM_MODES    = 4;
  localparam int DEF_CTRL_MIN     = 1;
  localparam int DEF_CTRL_MAX     = 128;
  localparam int DEF_DEB_TICKS    = 20;
  localparam int DEF_HOLD_TICKS   = 50000;
  localparam int DEF_REPEAT_TICKS = 10000;

  // Auto-repeat phase: waiting for the hold delay, then running at the period.
  typedef enum logic [0:0] {
    REP_HOLD = 1'b0,
    REP_RUN  = 1'b1
  } rep_state_t;

  // Width of the mode index; never below 1 bit.
  function automatic int mode_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ui_panel_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Interface : ui_panel_ctrl_if                                       |
// | Buttons, tick strobe and panel outputs of the UI panel controller. |
// | Rev       : 1.0 - initial release                                  |
// +--------------------------------------------------------------------+
interface ui_panel_ctrl_if #(
  parameter int NUM_MODES = ui_pkg::DEF_NUM_MODES,
  parameter int CTRL_W    = 8
);
  localparam int MODE_W = ui_pkg::mode_w(NUM_MODES);

  logic                 tick;
  logic [1:0]           h_pb;
  logic [1:0]           v_pb;
  logic [MODE_W-1:0]    mode;
  logic [NUM_MODES-1:0] mode_led;
  logic [CTRL_W-1:0]    ctrl;
  logic                 mode_upd;
  logic                 ctrl_upd;

  modport master (
    output tick, h_pb, v_pb,
    input  mode, mode_led, ctrl, mode_upd, ctrl_upd
  );

  modport slave (
    input  tick, h_pb, v_pb,
    output mode, mode_led, ctrl, mode_upd, ctrl_upd
  );
endinterface
`default_nettype wire

// File: rtl/ui_panel_ctrl_pb_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : pb_debounce                                               |
// | One push button: 2-flop synchroniser, tick-based debounce, press   |
// | edge detect and optional hold/auto-repeat events.                  |
// | Rev    : 1.0 - initial release                                     |
// +--------------------------------------------------------------------+
module pb_debounce #(
  parameter int DEB_TICKS    = ui_pkg::DEF_DEB_TICKS,
  parameter int REPEAT_EN    = 0,
  parameter int HOLD_TICKS   = ui_pkg::DEF_HOLD_TICKS,
  parameter int REPEAT_TICKS = ui_pkg::DEF_REPEAT_TICKS
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_tick,
  input  wire logic i_raw,
  output logic      o_evt
);
  import ui_pkg::*;

  localparam int DCW = $clog2(DEB_TICKS + 1);

  logic           r_sync1;
  logic           r_sync2;
  logic           r_level;
  logic           r_level_d;
  logic           r_press;
  logic [DCW-1:0] r_dcnt;
  logic           w_rep_evt;

  // Two-flop synchroniser for the asynchronous raw button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: accept a new level after DEB_TICKS consecutive differing ticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level <= 1'b0;
      r_dcnt  <= '0;
    end else if (r_sync2 == r_level) begin
      r_dcnt <= '0;
    end else if (i_tick) begin
      if (r_dcnt == DCW'(DEB_TICKS - 1)) begin
        r_level <= r_sync2;
        r_dcnt  <= '0;
      end else begin
        r_dcnt <= r_dcnt + DCW'(1);
      end
    end
  end

  // Press pulse on the debounced 0->1 transition only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level_d <= 1'b0;
      r_press   <= 1'b0;
    end else begin
      r_level_d <= r_level;
      r_press   <= r_level & ~r_level_d;
    end
  end

  generate
    if (REPEAT_EN != 0) begin : g_rep
      localparam int RCW = $clog2(HOLD_TICKS + REPEAT_TICKS + 1);

      rep_state_t     r_st;
      rep_state_t     w_st_nxt;
      logic [RCW-1:0] r_rcnt;
      logic [RCW-1:0] w_rcnt_nxt;
      logic           r_evt;
      logic           w_evt_nxt;

      // Repeat state, counter and event register.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_st   <= REP_HOLD;
          r_rcnt <= '0;
          r_evt  <= 1'b0;
        end else begin
          r_st   <= w_st_nxt;
          r_rcnt <= w_rcnt_nxt;
          r_evt  <= w_evt_nxt;
        end
      end

      // Hold delay first, then a fixed repeat period while the level stays high.
      always_comb begin
        w_st_nxt   = r_st;
        w_rcnt_nxt = r_rcnt;
        w_evt_nxt  = 1'b0;
        if (!r_level) begin
          w_st_nxt   = REP_HOLD;
          w_rcnt_nxt = '0;
        end else if (i_tick) begin
          case (r_st)
            REP_HOLD: begin
              if (r_rcnt == RCW'(HOLD_TICKS - 1)) begin
                w_evt_nxt  = 1'b1;
                w_rcnt_nxt = '0;
                w_st_nxt   = REP_RUN;
              end else begin
                w_rcnt_nxt = r_rcnt + RCW'(1);
              end
            end
            default: begin
              if (r_rcnt == RCW'(REPEAT_TICKS - 1)) begin
                w_evt_nxt  = 1'b1;
                w_rcnt_nxt = '0;
              end else begin
                w_rcnt_nxt = r_rcnt + RCW'(1);
              end
            end
          endcase
        end
      end

      assign w_rep_evt = r_evt;
    end else begin : g_norep
      assign w_rep_evt = 1'b0;
    end
  endgenerate

  assign o_evt = r_press | w_rep_evt;

endmodule
`default_nettype wire

// File: rtl/ui_panel_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : ui_panel_ctrl                                             |
// | Mode selector (next/prev buttons) and wrapping control word        |
// | (up/down buttons with auto-repeat) with registered update pulses.  |
// | Rev    : 1.0 - initial release                                     |
// +--------------------------------------------------------------------+
module ui_panel_ctrl #(
  parameter int NUM_MODES    = ui_pkg::DEF_NUM_MODES,
  parameter int MODE_WRAP    = 0,
  parameter int CTRL_W       = 8,
  parameter int CTRL_MIN     = ui_pkg::DEF_CTRL_MIN,
  parameter int CTRL_MAX     = ui_pkg::DEF_CTRL_MAX,
  parameter int DEB_TICKS    = ui_pkg::DEF_DEB_TICKS,
  parameter int HOLD_TICKS   = ui_pkg::DEF_HOLD_TICKS,
  parameter int REPEAT_TICKS = ui_pkg::DEF_REPEAT_TICKS
) (
  input wire logic         clk,
  input wire logic         rst,
  ui_panel_ctrl_if.slave   bus
);
  import ui_pkg::*;

  localparam int MODE_W = mode_w(NUM_MODES);

  localparam logic [MODE_W-1:0] c_MODE_MAX = MODE_W'(NUM_MODES - 1);
  localparam logic [CTRL_W-1:0] c_CTRL_MIN = CTRL_W'(CTRL_MIN);
  localparam logic [CTRL_W-1:0] c_CTRL_MAX = CTRL_W'(CTRL_MAX);

  generate
    if (CTRL_MIN >= CTRL_MAX || 64'(CTRL_MAX) >= (64'(1) << CTRL_W) ||
        NUM_MODES < 2 || NUM_MODES > 16) begin : g_param_err
      $error("ui_panel_ctrl: illegal NUM_MODES / CTRL_MIN / CTRL_MAX / CTRL_W");
    end
  endgenerate

  logic w_next;
  logic w_prev;
  logic w_up;
  logic w_dn;

  pb_debounce #(.DEB_TICKS(DEB_TICKS), .REPEAT_EN(0),
                .HOLD_TICKS(HOLD_TICKS), .REPEAT_TICKS(REPEAT_TICKS)) u_pb_next (
    .clk(clk), .rst(rst), .i_tick(bus.tick), .i_raw(bus.h_pb[1]), .o_evt(w_next));

  pb_debounce #(.DEB_TICKS(DEB_TICKS), .REPEAT_EN(0),
                .HOLD_TICKS(HOLD_TICKS), .REPEAT_TICKS(REPEAT_TICKS)) u_pb_prev (
    .clk(clk), .rst(rst), .i_tick(bus.tick), .i_raw(bus.h_pb[0]), .o_evt(w_prev));

  pb_debounce #(.DEB_TICKS(DEB_TICKS), .REPEAT_EN(1),
                .HOLD_TICKS(HOLD_TICKS), .REPEAT_TICKS(REPEAT_TICKS)) u_pb_up (
    .clk(clk), .rst(rst), .i_tick(bus.tick), .i_raw(bus.v_pb[0]), .o_evt(w_up));

  pb_debounce #(.DEB_TICKS(DEB_TICKS), .REPEAT_EN(1),
                .HOLD_TICKS(HOLD_TICKS), .REPEAT_TICKS(REPEAT_TICKS)) u_pb_dn (
    .clk(clk), .rst(rst), .i_tick(bus.tick), .i_raw(bus.v_pb[1]), .o_evt(w_dn));

  logic [MODE_W-1:0]    r_mode;
  logic [NUM_MODES-1:0] r_mode_led;
  logic                 r_mode_upd;
  logic [CTRL_W-1:0]    r_ctrl;
  logic                 r_ctrl_upd;

  logic [MODE_W-1:0]    w_mode_nxt;
  logic                 w_mode_chg;
  logic [CTRL_W-1:0]    w_ctrl_nxt;
  logic                 w_ctrl_chg;

  // Next mode: saturate or wrap at the ends; opposing events cancel.
  always_comb begin
    w_mode_nxt = r_mode;
    w_mode_chg = 1'b0;
    if (w_next && !w_prev) begin
      if (r_mode != c_MODE_MAX) begin
        w_mode_nxt = r_mode + MODE_W'(1);
        w_mode_chg = 1'b1;
      end else if (MODE_WRAP != 0) begin
        w_mode_nxt = '0;
        w_mode_chg = 1'b1;
      end
    end else if (w_prev && !w_next) begin
      if (r_mode != '0) begin
        w_mode_nxt = r_mode - MODE_W'(1);
        w_mode_chg = 1'b1;
      end else if (MODE_WRAP != 0) begin
        w_mode_nxt = c_MODE_MAX;
        w_mode_chg = 1'b1;
      end
    end
  end

  // Next control word: always wraps between CTRL_MIN and CTRL_MAX.
  always_comb begin
    w_ctrl_nxt = r_ctrl;
    w_ctrl_chg = 1'b0;
    if (w_up && !w_dn) begin
      w_ctrl_nxt = (r_ctrl == c_CTRL_MAX) ? c_CTRL_MIN : r_ctrl + CTRL_W'(1);
      w_ctrl_chg = 1'b1;
    end else if (w_dn && !w_up) begin
      w_ctrl_nxt = (r_ctrl == c_CTRL_MIN) ? c_CTRL_MAX : r_ctrl - CTRL_W'(1);
      w_ctrl_chg = 1'b1;
    end
  end

  // Mode, its one-hot LED decode and update pulse are registered together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode     <= '0;
      r_mode_led <= NUM_MODES'(1);
      r_mode_upd <= 1'b0;
    end else begin
      r_mode     <= w_mode_nxt;
      r_mode_led <= NUM_MODES'(1) << w_mode_nxt;
      r_mode_upd <= w_mode_chg;
    end
  end

  // Control word and its update pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl     <= c_CTRL_MIN;
      r_ctrl_upd <= 1'b0;
    end else begin
      r_ctrl     <= w_ctrl_nxt;
      r_ctrl_upd <= w_ctrl_chg;
    end
  end

  assign bus.mode     = r_mode;
  assign bus.mode_led = r_mode_led;
  assign bus.mode_upd = r_mode_upd;
  assign bus.ctrl     = r_ctrl;
  assign bus.ctrl_upd = r_ctrl_upd;

endmodule
`default_nettype wire

// File: doc/ui_panel_ctrl.md
UI_PANEL_CTRL -- requirements
Module: ui_panel_ctrl

Interface
REQ-001 Parameter NUM_MODES, default 4: number of display modes (2..16).
REQ-002 Parameter MODE_WRAP, default 0: 0 = mode index saturates at its ends, 1 = mode index wraps.
REQ-003 Parameter CTRL_W, default 8: width of the control word.
REQ-004 Parameter CTRL_MIN, default 1; CTRL_MAX, default 128: inclusive control-word range.
REQ-005 Parameter DEB_TICKS, default 20: ticks a raw button level must be stable to be accepted.
REQ-006 Parameter HOLD_TICKS, default 50000; REPEAT_TICKS, default 10000: auto-repeat start delay and auto-repeat period, in ticks.
REQ-007 clk  in  1  system clock; single clock domain.
REQ-008 rst  in  1  reset; asynchronous, active-high.
REQ-009 tick  in  1  one-clk-cycle timing strobe; all debounce and repeat counters advance only on tick.
REQ-010 h_pb  in  2  raw asynchronous buttons; [1] = mode next, [0] = mode previous.
REQ-011 v_pb  in  2  raw asynchronous buttons; [0] = ctrl up, [1] = ctrl down.
REQ-012 mode  out  $clog2(NUM_MODES)  current mode index.
REQ-013 mode_led  out  NUM_MODES  one-hot decode of mode.
REQ-014 ctrl  out  CTRL_W  current control word.
REQ-015 mode_upd  out  1  one-cycle pulse in the cycle after mode changes.
REQ-016 ctrl_upd  out  1  one-cycle pulse in the cycle after ctrl changes.

Function
REQ-017 Each raw button SHALL pass through a 2-flop synchroniser before any other logic.
REQ-018 The debounced level SHALL take the synchronised value only after DEB_TICKS consecutive ticks of a constant value differing from the current debounced level; any mismatch restarts the count.
REQ-019 A press event SHALL be a one-clk pulse in the cycle the debounced level goes from 0 to 1; releases SHALL generate no event.
REQ-020 For v_pb only, while a debounced level stays 1: one repeat event after HOLD_TICKS ticks, then one every REPEAT_TICKS ticks until release.
REQ-021 A mode-next event SHALL increment mode; at NUM_MODES-1 it holds (MODE_WRAP=0) or goes to 0 (MODE_WRAP=1).
REQ-022 A mode-previous event SHALL decrement mode; at 0 it holds (MODE_WRAP=0) or goes to NUM_MODES-1 (MODE_WRAP=1).
REQ-023 A ctrl-up event SHALL increment ctrl; at CTRL_MAX it goes to CTRL_MIN.
REQ-024 A ctrl-down event SHALL decrement ctrl; at CTRL_MIN it goes to CTRL_MAX.
REQ-025 Opposing events (next and previous, or up and down) in the same cycle SHALL leave the value unchanged and SHALL assert no upd pulse.
REQ-026 mode and ctrl SHALL update in the clk cycle after the event pulse; the upd pulse SHALL coincide with that new value.
REQ-027 A saturated hold (REQ-021, REQ-022) SHALL not assert mode_upd.
REQ-028 mode_led SHALL be registered together with mode, never combinationally glitching.
REQ-029 Latency from a clean raw press to the new output value SHALL be 2 clk + DEB_TICKS ticks + 2 clk.

Reset
REQ-030 While rst = 1, and for its whole duration: mode = 0, mode_led = 1, ctrl = CTRL_MIN, mode_upd = 0, ctrl_upd = 0, every debounced level = 0, every counter = 0.
REQ-031 A button held through reset deassertion SHALL produce exactly one press event after DEB_TICKS ticks.
REQ-032 Reset asserted mid-debounce or mid-repeat SHALL abort the count with no event generated.

Structure
REQ-033 Package ui_pkg SHALL hold the default constants (NUM_MODES, CTRL_MIN, CTRL_MAX, DEB_TICKS, HOLD_TICKS, REPEAT_TICKS) and a function returning mode width.
REQ-034 Sub-module pb_debounce (synchroniser, debounce counter, edge detect, optional repeat enabled by parameter) SHALL be instantiated four times.
REQ-035 Elaboration SHALL fail if CTRL_MIN >= CTRL_MAX, CTRL_MAX >= 2**CTRL_W, or NUM_MODES < 2.

Verification
REQ-036 tick = 1 every clk, DEB_TICKS = 4: v_pb[0] bounces 0/1 for 3 cycles, then stays 1 -> exactly one ctrl_upd; ctrl 1 -> 2.
REQ-037 ctrl = 128, one up press -> ctrl = 1; ctrl = 1, one down press -> ctrl = 128; ctrl_upd pulses once per press.
REQ-038 MODE_WRAP = 0, mode = 3, h_pb[1] press -> mode stays 3, no mode_upd; MODE_WRAP = 1 -> mode = 0, mode_led = 4'b0001.
REQ-039 HOLD_TICKS = 10, REPEAT_TICKS = 5, v_pb[0] held 30 ticks after debounce -> ctrl advances by 1 + 1 + 4 = 6 (press, hold, four repeats).
REQ-040 v_pb[0] and v_pb[1] rise in the same cycle and are debounced together -> ctrl unchanged, no ctrl_upd.
REQ-041 rst asserted 2 ticks into a debounce of h_pb[1], then released with the button still held -> mode stays 0 until DEB_TICKS ticks after release, then mode = 1.
